// File: rtl/uart_rx_os16_if.sv
// Receive-side bundle for uart_rx_os16: serial line in, byte/strobe/status out.
// Optional macro UART_RX_PARITY_EN adds the parity_err strobe.
//
// Handshake: no ready/backpressure. data_valid, frame_err and parity_err are
// one-cycle strobes; data stays stable from a data_valid strobe until the next
// good frame, so the consumer must capture it within that window.
interface uart_rx_os16_if #(
  parameter int DATA_BITS = 8
);
  logic                 rxd;
  logic [DATA_BITS-1:0] data;
  logic                 data_valid;
  logic                 frame_err;
  logic                 busy;
  logic [2:0]           fsm_state;
`ifdef UART_RX_PARITY_EN
  logic                 parity_err;

  modport master (input rxd, output data, data_valid, frame_err, busy, fsm_state, parity_err);
  modport slave  (output rxd, input data, data_valid, frame_err, busy, fsm_state, parity_err);
`else
  modport master (input rxd, output data, data_valid, frame_err, busy, fsm_state);
  modport slave  (output rxd, input data, data_valid, frame_err, busy, fsm_state);
`endif
endinterface

// File: rtl/uart_rx_os16.sv
// 16x oversampling UART receiver, single clock domain with an internal tick enable.
// Optional macro UART_RX_PARITY_EN adds an even-parity bit after the data bits.
module uart_rx_os16 #(
  parameter int TICK_DIV  = 326,
  parameter int DATA_BITS = 8
) (
  input  logic            clk_50m,
  input  logic            rst,
  uart_rx_os16_if.master  bus
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BW = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3,
    S_BREAK  = 3'd4
`ifdef UART_RX_PARITY_EN
    , S_PARITY = 3'd5
`endif
  } state_t;

  state_t               state;
  logic                 rxd_meta;
  logic                 rxd_s;
  logic [TW-1:0]        tick_cnt;
  logic                 tick;
  logic [3:0]           os_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] data_r;
  logic                 data_valid_r;
  logic                 frame_err_r;
  logic                 busy_r;
`ifdef UART_RX_PARITY_EN
  logic                 par_bit;
  logic                 parity_err_r;
`endif

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
    end else begin
      rxd_meta <= bus.rxd;
      rxd_s    <= rxd_meta;
    end
  end

  assign tick = (tick_cnt == TW'(TICK_DIV - 1));

  always_ff @(posedge clk_50m) begin
    if (rst || tick) tick_cnt <= '0;
    else             tick_cnt <= tick_cnt + TW'(1);
  end

  // os_cnt free-wraps on every tick outside IDLE/BREAK; the 15 sample points
  // therefore land on bit centres once START has realigned it at mid-start.
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      state        <= S_IDLE;
      os_cnt       <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
      data_r       <= '0;
      data_valid_r <= 1'b0;
      frame_err_r  <= 1'b0;
      busy_r       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit      <= 1'b0;
      parity_err_r <= 1'b0;
`endif
    end else begin
      data_valid_r <= 1'b0;
      frame_err_r  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_r <= 1'b0;
`endif
      if (tick) begin
        case (state)
          S_IDLE: begin
            if (!rxd_s) begin
              state  <= S_START;
              os_cnt <= '0;
              busy_r <= 1'b1;
            end
          end
          S_START: begin
            if (os_cnt == 4'd7) begin
              os_cnt <= '0;
              if (!rxd_s) begin
                state   <= S_DATA;
                bit_cnt <= '0;
              end else begin
                state  <= S_IDLE;
                busy_r <= 1'b0;
              end
            end else begin
              os_cnt <= os_cnt + 4'd1;
            end
          end
          S_DATA: begin
            os_cnt <= os_cnt + 4'd1;
            if (os_cnt == 4'd15) begin
              shreg   <= {rxd_s, shreg[DATA_BITS-1:1]};
              bit_cnt <= bit_cnt + BW'(1);
              if (bit_cnt == BW'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                state <= S_PARITY;
`else
                state <= S_STOP;
`endif
              end
            end
          end
`ifdef UART_RX_PARITY_EN
          S_PARITY: begin
            os_cnt <= os_cnt + 4'd1;
            if (os_cnt == 4'd15) begin
              par_bit <= rxd_s;
              state   <= S_STOP;
            end
          end
`endif
          S_STOP: begin
            os_cnt <= os_cnt + 4'd1;
            if (os_cnt == 4'd15) begin
`ifdef UART_RX_PARITY_EN
              parity_err_r <= ^{shreg, par_bit};
`endif
              if (rxd_s) begin
                data_r       <= shreg;
                data_valid_r <= 1'b1;
                state        <= S_IDLE;
                busy_r       <= 1'b0;
              end else begin
                frame_err_r <= 1'b1;
                state       <= S_BREAK;
              end
            end
          end
          S_BREAK: begin
            if (rxd_s) begin
              state  <= S_IDLE;
              busy_r <= 1'b0;
            end
          end
          default: begin
            state  <= S_IDLE;
            busy_r <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.data       = data_r;
  assign bus.data_valid = data_valid_r;
  assign bus.frame_err  = frame_err_r;
  assign bus.busy       = busy_r;
  assign bus.fsm_state  = state;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err = parity_err_r;
`endif

endmodule

// File: tb/tb_uart_rx_os16.sv
// Directed bench for uart_rx_os16 with a shortened tick divider; received bytes
// are matched against an expected queue filled as frames are driven.
module tb_uart_rx_os16;

  localparam int TICK_DIV = 8;
  localparam int BIT      = 16 * TICK_DIV;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_rx_os16_if #(.DATA_BITS(8)) bus ();

  uart_rx_os16 #(.TICK_DIV(TICK_DIV), .DATA_BITS(8)) dut (
    .clk_50m (clk),
    .rst     (rst),
    .bus     (bus)
  );

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic [7:0] exp_q[$];
  int         dv_cnt = 0;
  int         fe_cnt = 0;
  int         pe_cnt = 0;
  int         last_dv_cyc = 0;
  logic       prev_dv = 1'b0;
  logic       prev_fe = 1'b0;
  logic       prev_pe = 1'b0;
`ifdef UART_RX_PARITY_EN
  logic       par_flip = 1'b0;
`endif

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: strobes must be single-cycle, received bytes come off the queue.
  always @(negedge clk) begin
    if (bus.data_valid === 1'b1) begin
      dv_cnt++;
      last_dv_cyc = cyc;
      check("dv_width", {31'd0, prev_dv}, 32'd0);
      check("dv_expected", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) check("rx_data", {24'd0, bus.data}, {24'd0, exp_q.pop_front()});
    end
    if (bus.frame_err === 1'b1) begin
      fe_cnt++;
      check("fe_width", {31'd0, prev_fe}, 32'd0);
    end
`ifdef UART_RX_PARITY_EN
    if (bus.parity_err === 1'b1) begin
      pe_cnt++;
      check("pe_width", {31'd0, prev_pe}, 32'd0);
    end
    prev_pe = bus.parity_err;
`endif
    prev_dv = bus.data_valid;
    prev_fe = bus.frame_err;
  end

  task automatic idle_bits(input int n);
    bus.rxd = 1'b1;
    repeat (n * BIT) @(negedge clk);
  endtask

  // Leaves the line at the stop-bit level so a stuck-low stop can be extended.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int bc);
    bus.rxd = 1'b0;
    repeat (bc) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.rxd = b[i];
      repeat (bc) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    bus.rxd = (^b) ^ par_flip;
    repeat (bc) @(negedge clk);
`endif
    bus.rxd = stop_bit;
    repeat (bc) @(negedge clk);
  endtask

  int d0, f0, p0, start_cyc, lat;

  initial begin
    bus.rxd = 1'b1;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_data", {24'd0, bus.data}, 32'd0);
    check("rst_dv", {31'd0, bus.data_valid}, 32'd0);
    check("rst_fe", {31'd0, bus.frame_err}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
`ifdef UART_RX_PARITY_EN
    check("rst_pe", {31'd0, bus.parity_err}, 32'd0);
`endif
    rst = 1'b0;
    idle_bits(2);

    // single 0x55 frame plus latency window
    d0 = dv_cnt; f0 = fe_cnt;
    exp_q.push_back(8'h55);
    start_cyc = cyc;
    send_frame(8'h55, 1'b1, BIT);
    lat = last_dv_cyc - start_cyc;
    check("t1_dv_count", dv_cnt - d0, 32'd1);
    check("t1_fe_count", fe_cnt - f0, 32'd0);
    check("t1_busy_after", {31'd0, bus.busy}, 32'd0);
    check("t1_data", {24'd0, bus.data}, 32'h55);
    check("t1_latency_window", {31'd0, (lat >= 1218 && lat <= 1228)}, 32'd1);
    idle_bits(1);

    // back-to-back with exactly one stop bit
    d0 = dv_cnt;
    exp_q.push_back(8'hA3);
    exp_q.push_back(8'h0F);
    send_frame(8'hA3, 1'b1, BIT);
    send_frame(8'h0F, 1'b1, BIT);
    idle_bits(1);
    check("t2_dv_count", dv_cnt - d0, 32'd2);
    check("t2_data", {24'd0, bus.data}, 32'h0F);

    // 4-tick glitch is a false start
    d0 = dv_cnt; f0 = fe_cnt;
    bus.rxd = 1'b0;
    repeat (4 * TICK_DIV) @(negedge clk);
    idle_bits(2);
    check("t3_dv_count", dv_cnt - d0, 32'd0);
    check("t3_fe_count", fe_cnt - f0, 32'd0);
    check("t3_busy", {31'd0, bus.busy}, 32'd0);
    check("t3_data_kept", {24'd0, bus.data}, 32'h0F);

    // bad stop, line held low (break), then recovery
    d0 = dv_cnt; f0 = fe_cnt;
    send_frame(8'h3C, 1'b0, BIT);
    repeat (20 * BIT) @(negedge clk);
    check("t4_fe_count", fe_cnt - f0, 32'd1);
    check("t4_dv_count", dv_cnt - d0, 32'd0);
    check("t4_data_kept", {24'd0, bus.data}, 32'h0F);
    check("t4_busy_in_break", {31'd0, bus.busy}, 32'd1);
    idle_bits(2);
    check("t4_busy_released", {31'd0, bus.busy}, 32'd0);
    check("t4_no_retrigger", fe_cnt - f0, 32'd1);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1, BIT);
    idle_bits(1);
    check("t4_next_dv", dv_cnt - d0, 32'd1);
    check("t4_next_data", {24'd0, bus.data}, 32'h81);

    // reset during data bit 4
    bus.rxd = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      bus.rxd = (i % 2 == 0) ? 1'b0 : 1'b1;
      repeat (BIT) @(negedge clk);
    end
    bus.rxd = 1'b1;
    repeat (BIT / 2) @(negedge clk);
    check("t5_busy_midframe", {31'd0, bus.busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_rst_data", {24'd0, bus.data}, 32'd0);
    check("t5_rst_busy", {31'd0, bus.busy}, 32'd0);
    check("t5_rst_dv", {31'd0, bus.data_valid}, 32'd0);
    check("t5_rst_fe", {31'd0, bus.frame_err}, 32'd0);
    d0 = dv_cnt; f0 = fe_cnt;
    idle_bits(6);
    check("t5_discarded", dv_cnt - d0, 32'd0);
    exp_q.push_back(8'hE7);
    send_frame(8'hE7, 1'b1, BIT);
    idle_bits(1);
    check("t5_next_dv", dv_cnt - d0, 32'd1);
    check("t5_next_data", {24'd0, bus.data}, 32'hE7);
    check("t5_fe_count", fe_cnt - f0, 32'd0);

    // +/-3 % baud mismatch
    d0 = dv_cnt;
    exp_q.push_back(8'h96);
    send_frame(8'h96, 1'b1, 124);
    idle_bits(1);
    exp_q.push_back(8'h69);
    send_frame(8'h69, 1'b1, 132);
    idle_bits(1);
    check("t6_dv_count", dv_cnt - d0, 32'd2);
    check("t6_data", {24'd0, bus.data}, 32'h69);

`ifdef UART_RX_PARITY_EN
    // wrong parity still delivers the byte
    d0 = dv_cnt; p0 = pe_cnt;
    par_flip = 1'b1;
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1, BIT);
    par_flip = 1'b0;
    idle_bits(1);
    check("t7_pe_count", pe_cnt - p0, 32'd1);
    check("t7_dv_count", dv_cnt - d0, 32'd1);
    check("t7_data", {24'd0, bus.data}, 32'h07);
    p0 = pe_cnt;
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1, BIT);
    idle_bits(1);
    check("t7_good_parity", pe_cnt - p0, 32'd0);
`else
    p0 = pe_cnt;
`endif

    check("queue_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
